// File: rtl/display_color_encoder.sv
// Per-pixel PWM colour encoder: turns one RGB pixel into three LED drive bits
// for the PWM sub-frame selected by 'cycle'.
module display_color_encoder #(
    parameter int DEPTH    = 8,
    parameter bit REGISTER = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3*DEPTH-1:0] pixel,
    input  logic [DEPTH-1:0]   cycle,
    output logic [2:0]         rgb
);

    logic [2:0] on_next;

    // Channel gi takes pixel field gi, so B (low field) drives rgb[0] and R drives rgb[2].
    // A zero level stays dark even at cycle 0.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_channel
            logic [DEPTH-1:0] level;
            assign level       = pixel[gi*DEPTH +: DEPTH];
            assign on_next[gi] = (level >= cycle) && (level != '0);
        end
    endgenerate

    generate
        if (REGISTER) begin : g_registered
            logic [2:0] rgb_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rgb_reg <= 3'b000;
                end else begin
                    rgb_reg <= on_next;
                end
            end
            assign rgb = rgb_reg;
        end else begin : g_combinational
            assign rgb = on_next;
        end
    endgenerate

endmodule

// File: tb/tb_display_color_encoder.sv
// Directed bench for display_color_encoder (REGISTER=1): reset, per-channel
// boundary sweeps, mixed pixels and the one-clock latency.
module tb_display_color_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] pixel;
    logic [7:0]  cycle;
    logic [2:0]  rgb;

    int total_checks  = 0;
    int passed_checks = 0;

    display_color_encoder #(.DEPTH(8), .REGISTER(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pixel (pixel),
        .cycle (cycle),
        .rgb   (rgb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] expected);
        total_checks++;
        if (got !== expected) begin
            $display("FAIL %s: rgb=%b expected %b", tag, got, expected);
        end else begin
            passed_checks++;
            $display("ok   %s: rgb=%b", tag, got);
        end
    endtask

    // Present one pixel/cycle on a falling edge; its result is checked on the next one.
    task automatic step(input logic [23:0] px, input logic [7:0] cy,
                        input logic [2:0] expected, input string tag);
        pixel = px;
        cycle = cy;
        @(negedge clk);
        check(tag, rgb, expected);
    endtask

    function automatic logic lit(input logic [7:0] level, input logic [7:0] cy);
        return (level >= cy) && (level != 8'd0);
    endfunction

    typedef struct {
        logic [23:0] px;
        logic [7:0]  cy;
        logic [2:0]  expected;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC] = '{
        '{24'h00ff01, 8'd0,   3'b011},
        '{24'h00ff01, 8'd1,   3'b011},
        '{24'h00ff01, 8'd2,   3'b010},
        '{24'hffff00, 8'd0,   3'b110},
        '{24'hffff80, 8'd128, 3'b111},
        '{24'hffff80, 8'd129, 3'b110},
        '{24'h808080, 8'd129, 3'b000},
        '{24'h000000, 8'd0,   3'b000},
        '{24'hff0001, 8'd255, 3'b100},
        '{24'h7f8081, 8'd128, 3'b011},
        '{24'h010203, 8'd2,   3'b011},
        '{24'hfefefe, 8'd255, 3'b000}
    };

    logic [7:0] levels [6] = '{8'd0, 8'd1, 8'd127, 8'd128, 8'd254, 8'd255};
    logic [7:0] cycles [9] = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd129, 8'd253, 8'd254, 8'd255};

    initial begin
        rst_n = 1'b0;
        pixel = 24'hffffff;
        cycle = 8'd0;
        @(negedge clk);
        check("reset", rgb, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release", rgb, 3'b111);

        // Spot checks on the blue channel.
        step({16'hffff, 8'd0},   8'd0,   3'b110, "blue_i0_c0");
        step({16'hffff, 8'd128}, 8'd128, 3'b111, "blue_i128_c128");
        step({16'hffff, 8'd128}, 8'd129, 3'b110, "blue_i128_c129");

        // Boundary sweeps: channel 0 = B, 1 = G, 2 = R; the other two sit at full scale.
        for (int ch = 0; ch < 3; ch++) begin
            for (int li = 0; li < 6; li++) begin
                for (int ci = 0; ci < 9; ci++) begin
                    logic [23:0] px;
                    logic [2:0]  expected;
                    px = 24'hffffff;
                    px[ch*8 +: 8] = levels[li];
                    expected = 3'b111;
                    expected[ch] = lit(levels[li], cycles[ci]);
                    step(px, cycles[ci], expected,
                         $sformatf("sweep ch%0d v=%0d c=%0d", ch, levels[li], cycles[ci]));
                end
            end
        end

        for (int k = 0; k < NVEC; k++) begin
            step(vecs[k].px, vecs[k].cy, vecs[k].expected,
                 $sformatf("vec%0d px=%06h c=%0d", k, vecs[k].px, vecs[k].cy));
        end

        // Latency: a new input must not show before the next rising edge.
        step(24'hffffff, 8'd0, 3'b111, "latency_setup");
        pixel = 24'h000000;
        cycle = 8'd0;
        #1;
        check("latency_hold", rgb, 3'b111);
        @(negedge clk);
        check("latency_update", rgb, 3'b000);

        // Mid-stream reset then resume.
        pixel = 24'hffffff;
        cycle = 8'd7;
        rst_n = 1'b0;
        @(negedge clk);
        check("midstream_reset", rgb, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        check("midstream_resume", rgb, 3'b111);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
